// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 streaming convolution filter:
// kernel codes, coefficient table, per-kernel shift and accumulator sizing.
package filter_pkg;

  typedef enum logic [1:0] {
    KERN_IDENT = 2'd0,
    KERN_GAUSS = 2'd1,
    KERN_SHARP = 2'd2,
    KERN_LAPL  = 2'd3
  } kern_t;

  typedef logic signed [4:0] coef_t;

  localparam int FILTER_LAT = 4;

  // Indexed [kernel][row top->bottom][column left->right].
  localparam coef_t COEF [4][3][3] = '{
    '{'{5'sd0, 5'sd0, 5'sd0}, '{5'sd0, 5'sd1, 5'sd0}, '{5'sd0, 5'sd0, 5'sd0}},
    '{'{5'sd1, 5'sd2, 5'sd1}, '{5'sd2, 5'sd4, 5'sd2}, '{5'sd1, 5'sd2, 5'sd1}},
    '{'{5'sd0, -5'sd1, 5'sd0}, '{-5'sd1, 5'sd5, -5'sd1}, '{5'sd0, -5'sd1, 5'sd0}},
    '{'{-5'sd1, -5'sd1, -5'sd1}, '{-5'sd1, 5'sd8, -5'sd1}, '{-5'sd1, -5'sd1, -5'sd1}}
  };

  localparam logic [2:0] SHIFT [4] = '{3'd0, 3'd4, 3'd0, 3'd0};

  function automatic int acc_width(input int pix_w);
    return pix_w + 6;
  endfunction

endpackage

// File: rtl/filter_stream_line_buffer_2r.sv
// Two-line buffer: write at the column address, registered read of the
// previous two rows at the same column (read-first, BRAM friendly).
module line_buffer_2r
  import filter_pkg::*;
#(
  parameter int PIX_W    = 7,
  parameter int H_ACTIVE = 320,
  parameter int AW       = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] data_i,
  output logic [PIX_W-1:0] row1_o,
  output logic [PIX_W-1:0] row2_o
);

  logic [PIX_W-1:0] ram1_q [H_ACTIVE];
  logic [PIX_W-1:0] ram2_q [H_ACTIVE];

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      ram1_q[addr_i] <= data_i;
      ram2_q[addr_i] <= ram1_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row1_o <= '0;
      row2_o <= '0;
    end else if (we_i) begin
      row1_o <= ram1_q[addr_i];
      row2_o <= ram2_q[addr_i];
    end
  end

endmodule

// File: rtl/filter_stream.sv
// Streaming 3x3 convolution with two-line buffer, frame-latched kernel select
// and clamped output. FILTER_CLIP_CNT_EN adds a per-frame clip counter port.
module filter_stream
  import filter_pkg::*;
#(
  parameter int PIX_W          = 7,
  parameter int H_ACTIVE       = 320,
  parameter int V_ACTIVE       = 240,
  parameter int DEFAULT_KERNEL = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [PIX_W-1:0] pixel_data_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic [1:0]       kernel_sel_in,
`ifdef FILTER_CLIP_CNT_EN
  output logic [15:0]      clip_count_out,
`endif
  output logic             data_valid_out,
  output logic [PIX_W-1:0] pixel_data_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out
);

  localparam int ACC_W = acc_width(PIX_W);
  localparam int AW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [PIX_W-1:0] p,
                                                       input coef_t c);
    logic signed [ACC_W-1:0] pe, ce;
    pe = signed'(ACC_W'(p));
    ce = ACC_W'(c);
    return pe * ce;
  endfunction

  logic accept, at_origin;
  assign accept    = data_valid_in && (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
  assign at_origin = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);

  logic [PIX_W-1:0] row1, row2;
  line_buffer_2r #(.PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .AW(AW)) u_lb (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .we_i   (accept),
    .addr_i (hcount_in[AW-1:0]),
    .data_i (pixel_data_in),
    .row1_o (row1),
    .row2_o (row2)
  );

  kern_t            kern_q;
  logic             frame_sync_q;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] win [3][3];
  logic             v1_q, v2_q, v3_q;
  logic [10:0]      hc1_q, hc2_q, hc3_q;
  logic [9:0]       vc1_q, vc2_q, vc3_q;
  logic [2:0]       sh2_q;
  logic signed [ACC_W-1:0] rsum_d [3];
  logic signed [ACC_W-1:0] rsum_q [3];
  logic signed [ACC_W-1:0] acc3_q;
  logic             clip_lo, clip_hi;
  logic [PIX_W-1:0] pix_d;

  // Newest column comes straight from the line-buffer read registers and pix_q.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
    end
    win[0][2] = row2;
    win[1][2] = row1;
    win[2][2] = pix_q;
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rsum_d[r] = '0;
      for (int c = 0; c < 3; c++)
        rsum_d[r] = rsum_d[r] + mac_term(win[r][c], COEF[kern_q][r][c]);
    end
  end

  always_comb begin
    clip_lo = (acc3_q < 0);
    clip_hi = (acc3_q > PIX_MAX);
    if (clip_lo)      pix_d = '0;
    else if (clip_hi) pix_d = '1;
    else              pix_d = acc3_q[PIX_W-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      kern_q       <= kern_t'(DEFAULT_KERNEL[1:0]);
      frame_sync_q <= 1'b0;
      pix_q        <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
        rsum_q[r]   <= '0;
      end
      {v1_q, v2_q, v3_q}    <= '0;
      {hc1_q, hc2_q, hc3_q} <= '0;
      {vc1_q, vc2_q, vc3_q} <= '0;
      sh2_q          <= '0;
      acc3_q         <= '0;
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      // Stage 1: line-buffer read (in u_lb) and window shift.
      v1_q <= accept && frame_sync_q && (hcount_in >= 11'd2) && (vcount_in >= 10'd2);
      if (accept) begin
        pix_q <= pixel_data_in;
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win[r][1];
          win_q[r][1] <= win[r][2];
        end
        hc1_q <= hcount_in - 11'd1;
        vc1_q <= vcount_in - 10'd1;
      end
      if (at_origin) begin
        frame_sync_q <= 1'b1;
        kern_q       <= kern_t'(kernel_sel_in);
      end
      // Stage 2: products and row partial sums.
      v2_q  <= v1_q;
      hc2_q <= hc1_q;
      vc2_q <= vc1_q;
      sh2_q <= SHIFT[kern_q];
      for (int r = 0; r < 3; r++) rsum_q[r] <= rsum_d[r];
      // Stage 3: total and normalising shift.
      v3_q   <= v2_q;
      hc3_q  <= hc2_q;
      vc3_q  <= vc2_q;
      acc3_q <= (rsum_q[0] + rsum_q[1] + rsum_q[2]) >>> sh2_q;
      // Stage 4: clamp; outputs hold between valid beats.
      data_valid_out <= v3_q;
      if (v3_q) begin
        pixel_data_out <= pix_d;
        hcount_out     <= hc3_q;
        vcount_out     <= vc3_q;
      end
    end
  end

`ifdef FILTER_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      clip_cnt_q <= '0;
    else if (at_origin)
      clip_cnt_q <= '0;
    else if (v3_q && (clip_lo || clip_hi) && (clip_cnt_q != 16'hFFFF))
      clip_cnt_q <= clip_cnt_q + 16'd1;
  end
  assign clip_count_out = clip_cnt_q;
`endif

endmodule

// File: doc/filter_stream.md
Name: filter_stream

Overview:
- Parametrised successor to the fixed 3x3 line-buffer-plus-convolution filter.
- Streaming 3x3 convolution over a raster pixel stream, with integrated two-line buffer, runtime kernel selection and saturating output.
- Generalised in pixel width and frame geometry.
- Sits between the pixel-source pipeline and downstream thresholding/display, carrying hcount/vcount alongside pixels.

Parameters:
- PIX_W, 7: unsigned pixel width in bits.
- H_ACTIVE, 320: active pixels per line; line buffer depth.
- V_ACTIVE, 240: active lines per frame.
- DEFAULT_KERNEL, 0: kernel code loaded into the kernel register at reset.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- data_valid_in  in  1  input pixel qualifier.
- pixel_data_in  in  PIX_W  input pixel, unsigned.
- hcount_in  in  11  input column.
- vcount_in  in  10  input row.
- kernel_sel_in  in  2  kernel request: 0 identity, 1 gaussian, 2 sharpen, 3 laplacian.
- data_valid_out  out  1  output pixel qualifier.
- pixel_data_out  out  PIX_W  filtered pixel.
- hcount_out  out  11  column of the window centre.
- vcount_out  out  10  row of the window centre.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high via rst_in.
- Reset values: all outputs 0; valid pipeline cleared; window registers 0; kernel register = DEFAULT_KERNEL; frame_sync flag cleared. Line-buffer RAM contents are not reset (don't-care).
- Input is raster order; gaps are allowed (data_valid_in low on any cycle).
- Input beats with hcount_in >= H_ACTIVE or vcount_in >= V_ACTIVE are ignored: no buffer write, no window shift, no output.
- frame_sync:
  - Set by an accepted beat at (0,0).
  - Cleared only by reset.
  - While clear, no outputs are produced, so a mid-frame reset suppresses output until the next frame start.
- Kernel register samples kernel_sel_in only on an accepted beat at (0,0). A mid-frame change takes effect on the next frame.
- Each accepted beat:
  - Writes the pixel into the line buffer.
  - Shifts the 3x3 window by one column, with rows v-2, v-1, v at columns h-2, h-1, h.
- An output is generated for accepted input (h,v) when h>=2, v>=2 and frame_sync is set.
  - Centre coordinate is (h-1, v-1).
  - Output frame covers interior pixels 1..H_ACTIVE-2 by 1..V_ACTIVE-2; border pixels are not emitted.
- Latency is exactly 4 cycles from the qualifying data_valid_in beat to data_valid_out, independent of input gaps. Stages downstream of the window are free-running with a valid bit.
  - Stage 1: line-buffer read and window shift.
  - Stage 2: coefficient products and row partial sums.
  - Stage 3: total sum and arithmetic shift.
  - Stage 4: clamp and register outputs.
- hcount_out/vcount_out are registered alongside the pixel.
- Between outputs, pixel and count outputs hold their last values and data_valid_out is low.
- Kernels, in rows top to bottom:
  - Identity: centre weight 1, shift 0.
  - Gaussian: [1 2 1; 2 4 2; 1 2 1], shift 4.
  - Sharpen: [0 -1 0; -1 5 -1; 0 -1 0], shift 0.
  - Laplacian: [-1 -1 -1; -1 8 -1; -1 -1 -1], shift 0.
- Arithmetic:
  - Signed accumulator of PIX_W+6 bits; no internal overflow is possible.
  - Shift is arithmetic right.
  - Result is clamped to [0, 2^PIX_W-1].
- Line wrap: the window is not flushed at hcount 0. Outputs for h<2 are suppressed, so stale columns never reach the output.

Optional Feature:
- Macro FILTER_CLIP_CNT_EN.
- Defined:
  - Adds output port clip_count_out [15:0].
  - Counts output pixels that were clamped, either low or high.
  - Saturates at 16'hFFFF.
  - Cleared by reset and at the accepted (0,0) beat of each frame.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- filter_pkg holds:
  - Kernel-code enum (KERN_IDENT, KERN_GAUSS, KERN_SHARP, KERN_LAPL).
  - Coefficient table as a 3x3 signed 5-bit constant array per kernel.
  - Per-kernel shift constant.
  - FILTER_LAT = 4.
  - Accumulator width function of PIX_W.
- One sub-module, line_buffer_2r:
  - Two H_ACTIVE x PIX_W RAMs, written at hcount, read one cycle later.
  - Returns rows v-1 and v-2.
  - Maps to BRAM.

Test Plan (bench parameters PIX_W=7, H_ACTIVE=8, V_ACTIVE=6):
- Identity, ramp pixel=h+8v, no gaps -> 4x6=24 outputs; pixel_data_out(c,r)=c+8r; first output 4 cycles after input (2,2) with counts (1,1).
- Gaussian, constant 100 frame with random valid gaps -> every output 100; each output exactly 4 cycles after its input beat.
- Laplacian, impulse 127 at (4,3) else 0 -> (4,3)=127 (clamped high); its 8 neighbours 0 (clamped low); all others 0; with FILTER_CLIP_CNT_EN, clip_count_out=9 at frame end.
- Sharpen, constant 50 -> all outputs 50; kernel_sel_in changed to 3 mid-frame -> rest of frame still 50; next frame all 0.
- Reset asserted mid-frame at (3,3) then stream resumes at (4,3) -> no outputs until after the next (0,0) beat; the following frame is fully correct.
- Beats with hcount=8 or vcount=6 injected -> no output produced and line-buffer contents unaffected; verified by the next frame's results.
